// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, EX-stage branch/jump encodings and the fetch FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } branch_t;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JR   = 2'b10,
    JMP_RSVD = 2'b11
  } jump_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    WAIT   = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: one-cycle capture when en; flush zeroes it and wins over en.
// Holds its contents whenever en is low, which is how stalls are applied.
module if_id_latch
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  en,
  input  logic  flush,
  input  word_t instr_in,
  input  word_t npc_in,
  input  logic  valid_in,
  output word_t instr_out,
  output word_t npc_out,
  output logic  valid_out
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_out <= '0;
      npc_out   <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      instr_out <= '0;
      npc_out   <= '0;
      valid_out <= 1'b0;
    end else if (en) begin
      instr_out <= instr_in;
      npc_out   <= npc_in;
      valid_out <= valid_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, redirect resolution and IF/ID latch; instr valid one edge after ihit.
// Backpressure: stall or a missing ihit holds PC and latch; redirects still apply; halt stops fetching until reset.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
)
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  word_t       iload,
  output logic        imemREN,
  output word_t       imemaddr,
  input  logic        stall,
  input  logic        halt,
  input  logic [1:0]  ex_branch,
  input  logic [1:0]  ex_jump,
  input  logic        ex_zero,
  input  word_t       ex_npc,
  input  word_t       ex_imm,
  input  logic [25:0] ex_jaddr,
  input  word_t       ex_rs,
  output word_t       instr,
  output word_t       npc,
  output logic        ivalid
);

  fetch_state_t state, next_state;
  word_t        pc, pc_next, pc_plus4, branch_tgt, target;
  logic         redirect, lat_en, lat_flush;

  assign pc_plus4   = pc + PC_STEP;
  assign branch_tgt = ex_npc + (ex_imm << 2);

  // Jumps are decoded first so they override any branch outcome.
  always_comb begin
    redirect = 1'b0;
    target   = branch_tgt;
    case (jump_t'(ex_jump))
      JMP_J: begin
        redirect = 1'b1;
        target   = {ex_npc[31:28], ex_jaddr, 2'b00};
      end
      JMP_JR: begin
        redirect = 1'b1;
        target   = ex_rs;
      end
      default: begin
        case (branch_t'(ex_branch))
          BR_BEQ:  redirect = ex_zero;
          BR_BNE:  redirect = !ex_zero;
          default: redirect = 1'b0;
        endcase
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      pc    <= PC_INIT;
    end else begin
      state <= next_state;
      pc    <= pc_next;
    end
  end

  always_comb begin
    next_state = state;
    pc_next    = pc;
    lat_en     = 1'b0;
    lat_flush  = 1'b0;
    case (state)
      RUN, WAIT: begin
        if (halt) begin
          next_state = HALTED;
          lat_flush  = 1'b1;
        end else begin
          next_state = ihit ? RUN : WAIT;
          if (redirect) begin
            // Fetched word (if any) belongs to the wrong path; drop it.
            pc_next   = target & 32'hFFFF_FFFC;
            lat_flush = 1'b1;
          end else if (ihit && !stall) begin
            pc_next = pc_plus4;
            lat_en  = 1'b1;
          end
        end
      end
      default: begin
        next_state = HALTED;
        lat_flush  = 1'b1;
      end
    endcase
  end

  assign imemREN  = (state != HALTED);
  assign imemaddr = pc;

  if_id_latch u_if_id (
    .CLK       (CLK),
    .nRST      (nRST),
    .en        (lat_en),
    .flush     (lat_flush),
    .instr_in  (iload),
    .npc_in    (pc_plus4),
    .valid_in  (1'b1),
    .instr_out (instr),
    .npc_out   (npc),
    .valid_out (ivalid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives a scenario and checks hand-computed results.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  word_t       iload;
  logic        imemREN;
  word_t       imemaddr;
  logic        stall, halt;
  logic [1:0]  ex_branch, ex_jump;
  logic        ex_zero;
  word_t       ex_npc, ex_imm, ex_rs;
  logic [25:0] ex_jaddr;
  word_t       instr, npc;
  logic        ivalid;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .halt(halt),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_zero(ex_zero),
    .ex_npc(ex_npc), .ex_imm(ex_imm), .ex_jaddr(ex_jaddr), .ex_rs(ex_rs),
    .instr(instr), .npc(npc), .ivalid(ivalid)
  );

  always #5 CLK = ~CLK;

  task automatic clear_ex();
    stall = 0; halt = 0; ex_branch = 2'b00; ex_jump = 2'b00; ex_zero = 0;
    ex_npc = '0; ex_imm = '0; ex_jaddr = '0; ex_rs = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 0; ihit = 0; iload = '0; clear_ex();
    #2;
    n_cmp++; if (imemaddr !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", imemaddr, 32'h0); end
    n_cmp++; if (instr !== 32'h0 || npc !== 32'h0 || ivalid !== 1'b0) begin n_err++; $display("FAIL reset_latch got=%h/%h/%b exp=0/0/0", instr, npc, ivalid); end
    tick(); tick();
    nRST = 1;
    n_cmp++; if (imemREN !== 1'b1) begin n_err++; $display("FAIL reset_ren got=%b exp=1", imemREN); end
  endtask

  task automatic test_stream();
    ihit = 1; iload = 32'h2001_0005;
    n_cmp++; if (imemaddr !== 32'h0) begin n_err++; $display("FAIL stream_addr0 got=%h exp=0", imemaddr); end
    tick();
    n_cmp++; if (imemaddr !== 32'h4) begin n_err++; $display("FAIL stream_addr4 got=%h exp=4", imemaddr); end
    n_cmp++; if (instr !== 32'h2001_0005 || npc !== 32'h4 || ivalid !== 1'b1) begin n_err++; $display("FAIL stream_latch got=%h/%h/%b exp=20010005/4/1", instr, npc, ivalid); end
    tick();
    n_cmp++; if (imemaddr !== 32'h8 || npc !== 32'h8) begin n_err++; $display("FAIL stream_addr8 got=%h/%h exp=8/8", imemaddr, npc); end
  endtask

  task automatic test_wait();
    ihit = 0; iload = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imemaddr !== 32'h8 || instr !== 32'h2001_0005 || npc !== 32'h8 || imemREN !== 1'b1) begin n_err++; $display("FAIL wait_hold[%0d] got=%h/%h/%h/%b exp=8/20010005/8/1", i, imemaddr, instr, npc, imemREN); end
    end
    ihit = 1; iload = 32'hAAAA_0001;
    tick();
    n_cmp++; if (imemaddr !== 32'hC || instr !== 32'hAAAA_0001 || npc !== 32'hC) begin n_err++; $display("FAIL wait_resume got=%h/%h/%h exp=c/aaaa0001/c", imemaddr, instr, npc); end
  endtask

  task automatic test_branch();
    ihit = 1; iload = 32'h5555_5555;
    ex_branch = 2'b01; ex_zero = 1; ex_npc = 32'h10; ex_imm = 32'hFFFF_FFFE;
    tick();
    n_cmp++; if (imemaddr !== 32'h8 || instr !== 32'h0 || ivalid !== 1'b0) begin n_err++; $display("FAIL beq_taken got=%h/%h/%b exp=8/0/0", imemaddr, instr, ivalid); end
    ex_zero = 0; iload = 32'h1111_0000;
    tick();
    n_cmp++; if (imemaddr !== 32'hC || instr !== 32'h1111_0000 || ivalid !== 1'b1) begin n_err++; $display("FAIL beq_not_taken got=%h/%h/%b exp=c/11110000/1", imemaddr, instr, ivalid); end
    ex_branch = 2'b10; ex_zero = 0; ex_imm = 32'h4;
    tick();
    n_cmp++; if (imemaddr !== 32'h20 || ivalid !== 1'b0) begin n_err++; $display("FAIL bne_taken got=%h/%b exp=20/0", imemaddr, ivalid); end
    ex_branch = 2'b11; ex_zero = 1;
    tick();
    n_cmp++; if (imemaddr !== 32'h24 || ivalid !== 1'b1) begin n_err++; $display("FAIL br_reserved got=%h/%b exp=24/1", imemaddr, ivalid); end
    clear_ex();
  endtask

  task automatic test_jump();
    ihit = 1; iload = 32'h7777_7777;
    ex_jump = 2'b10; ex_rs = 32'h0000_0103;
    ex_branch = 2'b01; ex_zero = 1; ex_npc = 32'h10; ex_imm = 32'h4;
    tick();
    n_cmp++; if (imemaddr !== 32'h100 || ivalid !== 1'b0) begin n_err++; $display("FAIL jr_target got=%h/%b exp=100/0", imemaddr, ivalid); end
    clear_ex();
    ex_jump = 2'b01; ex_jaddr = 26'h40; ex_npc = 32'h1000_0004;
    tick();
    n_cmp++; if (imemaddr !== 32'h1000_0100) begin n_err++; $display("FAIL j_target got=%h exp=10000100", imemaddr); end
    ex_jump = 2'b11;
    tick();
    n_cmp++; if (imemaddr !== 32'h1000_0104 || ivalid !== 1'b1) begin n_err++; $display("FAIL j_reserved got=%h/%b exp=10000104/1", imemaddr, ivalid); end
    clear_ex();
  endtask

  task automatic test_stall();
    ihit = 1; iload = 32'h1234_5678;
    tick();
    stall = 1; iload = 32'hFFFF_0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (imemaddr !== 32'h1000_0108 || instr !== 32'h1234_5678 || npc !== 32'h1000_0108 || imemREN !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] got=%h/%h/%h/%b exp=10000108/12345678/10000108/1", i, imemaddr, instr, npc, imemREN); end
    end
    ex_jump = 2'b01; ex_jaddr = 26'h10; ex_npc = 32'h0;
    tick();
    n_cmp++; if (imemaddr !== 32'h40 || instr !== 32'h0 || ivalid !== 1'b0) begin n_err++; $display("FAIL stall_redirect got=%h/%h/%b exp=40/0/0", imemaddr, instr, ivalid); end
    clear_ex();
  endtask

  task automatic test_wrap();
    ihit = 1; iload = 32'h0BAD_F00D;
    ex_jump = 2'b10; ex_rs = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (imemaddr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL jr_align got=%h exp=fffffffc", imemaddr); end
    clear_ex();
    tick();
    n_cmp++; if (imemaddr !== 32'h0 || npc !== 32'h0 || ivalid !== 1'b1) begin n_err++; $display("FAIL pc_wrap got=%h/%h/%b exp=0/0/1", imemaddr, npc, ivalid); end
    ex_branch = 2'b01; ex_zero = 1; ex_npc = 32'hFFFF_FFFC; ex_imm = 32'h2;
    tick();
    n_cmp++; if (imemaddr !== 32'h4) begin n_err++; $display("FAIL br_wrap got=%h exp=4", imemaddr); end
    clear_ex();
  endtask

  task automatic test_reset_in_wait();
    ihit = 0;
    tick();
    nRST = 0;
    #1;
    n_cmp++; if (imemaddr !== 32'h0 || ivalid !== 1'b0 || imemREN !== 1'b1) begin n_err++; $display("FAIL wait_reset got=%h/%b/%b exp=0/0/1", imemaddr, ivalid, imemREN); end
    tick();
    nRST = 1;
    ihit = 1; iload = 32'h2222_3333;
    n_cmp++; if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin n_err++; $display("FAIL wait_reset_rel got=%h/%b exp=0/1", imemaddr, imemREN); end
    tick();
    n_cmp++; if (imemaddr !== 32'h4 || instr !== 32'h2222_3333) begin n_err++; $display("FAIL wait_reset_fetch got=%h/%h exp=4/22223333", imemaddr, instr); end
  endtask

  task automatic test_halt();
    ihit = 1;
    ex_jump = 2'b01; ex_jaddr = 26'h8; ex_npc = 32'h0;
    tick();
    clear_ex();
    halt = 1;
    n_cmp++; if (imemaddr !== 32'h20 || imemREN !== 1'b1) begin n_err++; $display("FAIL halt_pre got=%h/%b exp=20/1", imemaddr, imemREN); end
    tick();
    n_cmp++; if (imemREN !== 1'b0 || imemaddr !== 32'h20 || ivalid !== 1'b0) begin n_err++; $display("FAIL halt_enter got=%b/%h/%b exp=0/20/0", imemREN, imemaddr, ivalid); end
    halt = 0; ex_jump = 2'b01; ex_jaddr = 26'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imemREN !== 1'b0 || imemaddr !== 32'h20 || ivalid !== 1'b0) begin n_err++; $display("FAIL halt_stay[%0d] got=%b/%h/%b exp=0/20/0", i, imemREN, imemaddr, ivalid); end
    end
    clear_ex();
    nRST = 0;
    tick();
    nRST = 1;
    n_cmp++; if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin n_err++; $display("FAIL halt_reset got=%h/%b exp=0/1", imemaddr, imemREN); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_reset_in_wait();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
